// File: rtl/iir_avr_sched.sv
// iir_avr_sched: four-channel IIR averager sharing one Q15 multiplier.
// Optional macro IIR_AVR_SAT_EN: saturate/clamp s instead of wrapping.
module iir_avr_sched #(
    parameter int          NCH = 4,
    parameter int          N   = 12,
    parameter logic [11:0] A   = 12'd2831
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    adc_valid,
    input  logic [14*NCH-1:0] adc_data,
    output logic [NCH-1:0]    adc_ready,
    input  logic [NCH-1:0]    ch_clr,
    output logic              avr_valid,
    output logic [1:0]        avr_ch,
    output logic [40:0]       avr_whole,
    output logic [40:0]       avr_frac,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CALC, OUTP} state_t;

    state_t state, state_nx;

    logic [40:0] s   [NCH];
    logic [3:0]  cnt [NCH];

    logic [1:0]     last_grant;
    logic [1:0]     cur_ch;
    logic [13:0]    cur_dat;
    logic           cur_warm;
    logic           kill;
    logic [NCH-1:0] elig;
    logic           gnt_any;
    logic [1:0]     gnt_ch;
    logic [13:0]    gnt_dat;
    logic [40:0]    mul_s;
    logic [52:0]    prod;
    logic [37:0]    m_sub;
    logic [40:0]    s_upd;
    logic           ld_out;

    // Round-robin pick of the first eligible channel after last_grant
    always_comb begin
        elig    = adc_valid & ~ch_clr;
        gnt_any = 1'b0;
        gnt_ch  = last_grant;
        for (int i = 1; i <= NCH; i++) begin
            if (!gnt_any && elig[2'(last_grant + 2'(i))]) begin
                gnt_any = 1'b1;
                gnt_ch  = 2'(last_grant + 2'(i));
            end
        end
    end

    // Mux the granted channel's sample and drive the one-hot ready
    always_comb begin
        gnt_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (2'(k) == gnt_ch) gnt_dat = adc_data[14*k +: 14];
        end
        adc_ready = '0;
        if (state == IDLE && gnt_any)
            adc_ready = {{(NCH-1){1'b0}}, 1'b1} << gnt_ch;
    end

    // Shared multiplier: CALC uses old s, OUTP uses the freshly written s
    always_comb begin
        mul_s = s[cur_ch];
        prod  = {41'd0, A} * {12'd0, mul_s};
        m_sub = cur_warm ? prod[52:15] : 38'd0;
    end

`ifdef IIR_AVR_SAT_EN
    logic [41:0] sum;
    logic [41:0] diff;

    // Saturating update: clamp at zero on underflow, all-ones on overflow
    always_comb begin
        sum  = {1'b0, mul_s} + {28'd0, cur_dat};
        diff = sum - {4'd0, m_sub};
        if (sum < {4'd0, m_sub})
            s_upd = '0;
        else if (diff[41])
            s_upd = '1;
        else
            s_upd = diff[40:0];
    end
`else
    // Wrapping update modulo 2^41
    always_comb begin
        s_upd = mul_s + {27'd0, cur_dat} - {3'd0, m_sub};
    end
`endif

    assign ld_out = (state == OUTP) && cur_warm && !kill && !ch_clr[cur_ch];
    assign busy   = (state != IDLE);

    // Next-state logic for the fixed three-step sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_any) state_nx = CALC;
            CALC:    state_nx = OUTP;
            OUTP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM register, grant bookkeeping and in-flight clear tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            cur_ch     <= 2'd0;
            cur_dat    <= '0;
            cur_warm   <= 1'b0;
            kill       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && gnt_any) begin
                last_grant <= gnt_ch;
                cur_ch     <= gnt_ch;
                cur_dat    <= gnt_dat;
                cur_warm   <= (cnt[gnt_ch] == 4'(N));
                kill       <= 1'b0;
            end else if (state == CALC && ch_clr[cur_ch]) begin
                kill <= 1'b1;
            end
        end
    end

    // Per-channel accumulator and warm-up counter; clear wins over write-back
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (rst || ch_clr[k]) begin
                s[k]   <= '0;
                cnt[k] <= '0;
            end else if (state == CALC && cur_ch == 2'(k)) begin
                s[k] <= s_upd;
                if (!cur_warm) cnt[k] <= cnt[k] + 4'd1;
            end
        end
    end

    // Result registers, held until the next result is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            avr_valid <= 1'b0;
            avr_ch    <= 2'd0;
            avr_whole <= '0;
            avr_frac  <= '0;
        end else begin
            avr_valid <= ld_out;
            if (ld_out) begin
                avr_ch    <= cur_ch;
                avr_whole <= {3'd0, prod[52:15]};
                avr_frac  <= {26'd0, prod[14:0]};
            end
        end
    end

endmodule

// File: tb/tb_iir_avr_sched.sv
// tb_iir_avr_sched: directed checks of the four-channel IIR averager.
// Expected values are hand-computed from A = 2831, N = 12.
module tb_iir_avr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  adc_valid;
    logic [55:0] adc_data;
    logic [3:0]  adc_ready;
    logic [3:0]  ch_clr;
    logic        avr_valid;
    logic [1:0]  avr_ch;
    logic [40:0] avr_whole;
    logic [40:0] avr_frac;
    logic        busy;

    int n_pass = 0;
    int n_tot  = 0;

    iir_avr_sched dut (
        .clk       (clk),
        .rst       (rst),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .adc_ready (adc_ready),
        .ch_clr    (ch_clr),
        .avr_valid (avr_valid),
        .avr_ch    (avr_ch),
        .avr_whole (avr_whole),
        .avr_frac  (avr_frac),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One sample through grant, CALC, OUTP; checks the result at T+3
    task automatic sample(input int ch, input logic [13:0] d,
                          input bit exp_v, input logic [40:0] ew,
                          input logic [40:0] ef, input bit clr_calc);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        adc_data = '0;
        adc_data[14*ch +: 14] = d;
        adc_valid = oh;
        #1;
        check("ready_grant", adc_ready, oh);
        tick();
        adc_valid = '0;
        if (clr_calc) ch_clr[ch] = 1'b1;
        #1;
        check("busy_calc", busy, 1);
        check("vld_calc", avr_valid, 0);
        tick();
        ch_clr = '0;
        #1;
        check("vld_outp", avr_valid, 0);
        tick();
        check("avr_valid", avr_valid, exp_v);
        if (exp_v) begin
            check("avr_whole", avr_whole, ew);
            check("avr_frac", avr_frac, ef);
            check("avr_ch", avr_ch, ch);
        end
    endtask

    initial begin
        rst       = 1'b0;
        adc_valid = '0;
        adc_data  = '0;
        ch_clr    = '0;
        tick();
        do_reset();
        check("rst_valid", avr_valid, 0);
        check("rst_ch", avr_ch, 0);
        check("rst_whole", avr_whole, 0);
        check("rst_frac", avr_frac, 0);
        check("rst_ready", adc_ready, 0);
        check("rst_busy", busy, 0);

        // ch0 warm-up then first IIR result
        for (int i = 0; i < 12; i++) sample(0, 14'd1000, 0, 0, 0, 0);
        sample(0, 14'd1000, 1, 41'd1033, 41'd20740, 0);
        tick();
        check("hold_valid", avr_valid, 0);
        check("hold_whole", avr_whole, 1033);

        // ch3 full-scale input
        for (int i = 0; i < 12; i++) sample(3, 14'd16383, 0, 0, 0, 0);
        sample(3, 14'd16383, 1, 41'd16933, 41'd1301, 0);

        // all channels valid: rotation and busy duty
        do_reset();
        adc_data  = {4{14'd7}};
        adc_valid = 4'hF;
        for (int g = 0; g < 8; g++) begin
            #1;
            check("rr_ready", adc_ready, 4'b0001 << (g % 4));
            check("rr_idle", busy, 0);
            tick();
            check("rr_calc_rdy", adc_ready, 0);
            check("rr_calc_busy", busy, 1);
            tick();
            check("rr_outp_rdy", adc_ready, 0);
            check("rr_outp_busy", busy, 1);
            tick();
        end
        adc_valid = '0;

        // fairness: ch1 raised while ch2 streams
        do_reset();
        adc_valid = 4'b0100;
        #1;
        check("fair_ch2", adc_ready, 4'b0100);
        tick();
        adc_valid = 4'b0110;
        tick();
        tick();
        check("fair_ch1", adc_ready, 4'b0010);
        tick();
        tick();
        tick();
        check("fair_ch2b", adc_ready, 4'b0100);
        adc_valid = '0;
        tick();
        tick();
        tick();

        // clear in flight on a warm ch0 sample
        do_reset();
        for (int i = 0; i < 12; i++) sample(0, 14'd1000, 0, 0, 0, 0);
        sample(0, 14'd1000, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) sample(0, 14'd1000, 0, 0, 0, 0);
        sample(0, 14'd1000, 1, 41'd1033, 41'd20740, 0);

        // clear vs grant
        do_reset();
        adc_valid = 4'b1010;
        ch_clr    = 4'b0010;
        #1;
        check("clr_grant", adc_ready, 4'b1000);
        tick();
        adc_valid = '0;
        ch_clr    = '0;
        tick();
        tick();

        // reset during OUTP of a result-bearing sample
        do_reset();
        for (int i = 0; i < 12; i++) sample(0, 14'd1000, 0, 0, 0, 0);
        adc_data  = {42'd0, 14'd1000};
        adc_valid = 4'b0001;
        tick();
        adc_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        check("rsto_valid", avr_valid, 0);
        check("rsto_whole", avr_whole, 0);
        check("rsto_frac", avr_frac, 0);
        check("rsto_ch", avr_ch, 0);
        check("rsto_busy", busy, 0);
        check("rsto_ready", adc_ready, 0);
        rst       = 1'b0;
        adc_valid = 4'hF;
        #1;
        check("rsto_grant", adc_ready, 4'b0001);
        tick();
        adc_valid = '0;
        check("rsto_valid2", avr_valid, 0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/iir_avr_sched.md
# iir_avr_sched

Time-shared scheduler and datapath for four-channel IIR averaging. Four 14-bit ADC streams share one Q15 coefficient multiplier. Each channel has its own accumulator state and warm-up counter. A round-robin arbiter admits one sample at a time and runs it through a fixed 3-cycle update sequence, producing a tagged whole/fractional average per accepted sample once that channel has warmed up.

## Interface
Parameters:
- NCH, 4: number of ADC channels (fixed at 4; channel index is 2 bits).
- N, 12: warm-up samples accumulated per channel before IIR operation starts.
- A, 2831: Q15 feedback coefficient (12-bit).

Ports:
- clk  in  1  clock; one clock for the whole block.
- rst  in  1  reset, synchronous, active-high.
- adc_valid  in  NCH  per-channel sample valid.
- adc_data  in  14*NCH  channel k occupies bits [14k+13:14k].
- adc_ready  out  NCH  one-hot; the sample is accepted on a cycle where adc_valid[k] & adc_ready[k].
- ch_clr  in  NCH  per-channel state clear.
- avr_valid  out  1  one-cycle result strobe.
- avr_ch  out  2  channel of the current result.
- avr_whole  out  41  integer part of the average.
- avr_frac  out  41  fractional part; bits [14:0] are significant, upper bits are 0.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
Per-channel state:
- s[k], 41 bits.
- cnt[k], 4 bits, saturating at N.
- warm[k] = (cnt[k] == N).

FSM has three states, IDLE → CALC → OUTP → IDLE.
- IDLE:
  - Eligible channels are those with adc_valid[k] & !ch_clr[k].
  - Round-robin grant starts from (last_grant+1) mod 4; after reset, last_grant = 3.
  - Grant drives adc_ready = one-hot for the granted channel (combinational in IDLE, 0 otherwise).
  - On a grant, latch channel and sample, then go to CALC. With no eligible channel, stay in IDLE.
- CALC:
  - If !warm: s += adc and cnt += 1.
  - If warm: m = A*s (53-bit product), then s ← s + adc − m[52:15].
  - Go to OUTP.
- OUTP:
  - If the sample was taken while the channel was warm: p = A*s_new, avr_whole ← p >> 15, avr_frac ← p[14:0], avr_ch ← channel.
  - Go to IDLE. avr_valid is high in the following cycle only when a result was loaded.
- Warm-up samples never produce avr_valid. The first result comes from sample N+1.
- Arithmetic is unsigned and wraps modulo 2^41, except as modified under Configuration.

Clear behaviour:
- ch_clr[k] zeroes s[k] and cnt[k] at the next edge, in any state.
- If channel k is in flight during CALC or OUTP: its write-back is suppressed, no avr_valid is issued, and the FSM still completes the sequence back to IDLE.
- A clear in the same cycle as a would-be grant makes that channel ineligible; the grant goes to the next eligible channel.

Reset:
- All s, cnt = 0; FSM = IDLE; last_grant = 3.
- avr_valid = 0, avr_ch = 0, avr_whole = 0, avr_frac = 0, adc_ready = 0, busy = 0.

## Timing
- Grant at cycle T (IDLE, adc_ready high); CALC at T+1; OUTP at T+2.
- avr_valid and new avr_* values appear in cycle T+3. That same cycle is IDLE, so the next grant can occur in T+3.
- Latency is 3 cycles; maximum throughput is one sample per 3 cycles.
- avr_whole, avr_frac and avr_ch hold their values until the next result.
- rst asserted mid-sequence aborts the sequence. Outputs return to reset values at the next edge.

## Configuration
- IIR_AVR_SAT_EN defined:
  - In CALC, s saturates at 2^41−1 on overflow.
  - If s + adc < m[52:15], s clamps to 0.
- IIR_AVR_SAT_EN undefined: modulo-2^41 wrap, no clamp logic synthesized.

## Test plan
- Reset, then constant adc = 1000 on ch0 only, 13 samples:
  - no avr_valid for samples 1–12;
  - after sample 12, s[0] = 12000;
  - sample 13 gives s[0] = 11964, avr_whole = 1033, avr_frac = 20740, avr_ch = 0, arriving 3 cycles after its grant.
- All four channels valid continuously:
  - grants go ch0, ch1, ch2, ch3, ch0 …, one every 3 cycles;
  - adc_ready is never multi-hot; busy is high 2 of every 3 cycles.
- Channel fairness: ch2 valid continuously and ch1 raised at an arbitrary cycle → ch1 is granted within 2 grants (≤6 cycles).
- Clear in flight: pulse ch_clr[0] during CALC of a warm ch0 sample → no avr_valid for that sample, s[0] = 0, cnt[0] = 0, and the next 12 ch0 samples are warm-up again.
- Clear vs grant: ch_clr[1] and adc_valid[1] together in IDLE with ch3 also valid → adc_ready = 4'b1000, ch1 sample not accepted.
- Synchronous reset asserted during OUTP → avr_valid stays 0, all outputs are 0 at the next edge, and the first post-reset grant goes to ch0.
